// File: rtl/rle_token_packer_if.sv
// ----------------------------------------------------------------------------
// rle_token_packer_if
//   Pixel-in / token-out bundle for rle_token_packer.
//   Pixel side : bit_in, bit_valid, eol, eof   (upstream -> packer)
//   Token side : token_valid, token_data       (packer -> consumer)
//                token_ready                   (consumer -> packer)
//   Status     : overflow (sticky drop flag)
//                frame_tokens (only with RLE_PACKER_STATS_EN defined)
//   Modports   : master = upstream/consumer side, slave = the packer.
// ----------------------------------------------------------------------------
interface rle_token_packer_if #(
    parameter int LEN_W = 11
);
    logic             bit_in;
    logic             bit_valid;
    logic             eol;
    logic             eof;
    logic             token_valid;
    logic             token_ready;
    logic [LEN_W+2:0] token_data;
    logic             overflow;
`ifdef RLE_PACKER_STATS_EN
    logic [15:0]      frame_tokens;

    modport master (
        output bit_in, bit_valid, eol, eof, token_ready,
        input  token_valid, token_data, overflow, frame_tokens
    );
    modport slave (
        input  bit_in, bit_valid, eol, eof, token_ready,
        output token_valid, token_data, overflow, frame_tokens
    );
`else
    modport master (
        output bit_in, bit_valid, eol, eof, token_ready,
        input  token_valid, token_data, overflow
    );
    modport slave (
        input  bit_in, bit_valid, eol, eof, token_ready,
        output token_valid, token_data, overflow
    );
`endif
endinterface

// File: rtl/rle_token_packer.sv
// ----------------------------------------------------------------------------
// rle_token_packer
//   Run-length encodes a binarised pixel mask into tokens
//   {value, eol, eof, length[LEN_W-1:0]} and buffers them in a
//   first-word-fall-through FIFO that accepts up to two tokens per cycle.
//   Every run produces exactly one token (runs longer than 2^LEN_W-1 are
//   split); tokens are lost only when the FIFO is full (sticky overflow).
//
//   Ports:
//     CLK      - pixel clock, rising edge
//     reset_n  - asynchronous active-low reset, release synchronised (2 flops)
//     bus      - rle_token_packer_if.slave (pixel input, token output, status)
//
//   Optional feature: define RLE_PACKER_STATS_EN to add bus.frame_tokens, the
//   number of tokens stored per frame (saturating at 0xFFFF).
// ----------------------------------------------------------------------------
module rle_token_packer #(
    parameter int LEN_W = 11,
    parameter int DEPTH = 16
) (
    input  logic               CLK,
    input  logic               reset_n,
    rle_token_packer_if.slave  bus
);
    localparam int                  TOK_W   = LEN_W + 3;
    localparam int                  AW      = $clog2(DEPTH);
    localparam logic [LEN_W-1:0]    MAX_LEN = '1;
    localparam logic [LEN_W-1:0]    LEN_ONE = LEN_W'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // ---------------- reset release synchroniser ----------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // ---------------- run state machine ----------------
    state_t             r_state;
    logic               r_val;
    logic [LEN_W-1:0]   r_len;
    logic [1:0]         r_n_push;
    logic [TOK_W-1:0]   r_push0;
    logic [TOK_W-1:0]   r_push1;
    logic               r_eof_pix;

    state_t             w_next_state;
    logic               w_next_val;
    logic [LEN_W-1:0]   w_next_len;
    logic [1:0]         w_n_emit;
    logic [TOK_W-1:0]   w_tok0;
    logic [TOK_W-1:0]   w_tok1;
    logic [TOK_W-1:0]   w_close;

    // The pixel first joins or opens a run (possibly closing the old one),
    // then eol closes whatever run the pixel ended up in.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_next_val   = r_val;
        w_next_len   = r_len;
        w_n_emit     = 2'd0;
        w_tok0       = '0;
        w_tok1       = '0;
        w_close      = '0;
        if (bus.bit_valid) begin
            w_next_state = S_RUN;
            if (r_state == S_RUN && bus.bit_in == r_val && r_len != MAX_LEN) begin
                w_next_len = r_len + 1'b1;
            end else begin
                if (r_state == S_RUN) begin
                    w_tok0   = {r_val, 2'b00, r_len};
                    w_n_emit = 2'd1;
                end
                w_next_val = bus.bit_in;
                w_next_len = LEN_ONE;
            end
            if (bus.eol) begin
                w_close = {w_next_val, 1'b1, bus.eof, w_next_len};
                if (w_n_emit == 2'd0) w_tok0 = w_close;
                else                  w_tok1 = w_close;
                w_n_emit     = w_n_emit + 2'd1;
                w_next_state = S_IDLE;
                w_next_len   = '0;
            end
        end
    end

    // Emitted tokens are registered; the FIFO stores them one cycle later.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        // NOTE: state is updated with <= so all flops see pre-edge values.
        if (!w_rst_n) begin
            r_state   <= S_IDLE;
            r_val     <= 1'b0;
            r_len     <= '0;
            r_n_push  <= 2'd0;
            r_push0   <= '0;
            r_push1   <= '0;
            r_eof_pix <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_val     <= w_next_val;
            r_len     <= w_next_len;
            r_n_push  <= w_n_emit;
            r_push0   <= w_tok0;
            r_push1   <= w_tok1;
            r_eof_pix <= bus.bit_valid && bus.eof;
        end
    end

    // ---------------- token FIFO ----------------
    logic [TOK_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_overflow;

    logic [AW:0]        w_free;
    logic [1:0]         w_n_store;
    logic               w_valid;
    logic               w_pop;
    logic [AW-1:0]      w_wr_ptr1;

    // Free space is taken before this cycle's pop; the older token wins.
    assign w_free    = (AW+1)'(DEPTH) - r_count;
    assign w_n_store = ((AW+1)'(r_n_push) > w_free) ? w_free[1:0] : r_n_push;
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && bus.token_ready;
    assign w_wr_ptr1 = r_wr_ptr + 1'b1;

    // NOTE: storage needs no reset; r_count alone defines which entries are live.
    always_ff @(posedge CLK) begin
        if (w_n_store != 2'd0) r_mem[r_wr_ptr]  <= r_push0;
        if (w_n_store == 2'd2) r_mem[w_wr_ptr1] <= r_push1;
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_store);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_n_store) - (AW+1)'(w_pop);
            if (w_n_store != r_n_push) r_overflow <= 1'b1;
        end
    end

    assign bus.token_valid = w_valid;
    assign bus.token_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.overflow    = r_overflow;

`ifdef RLE_PACKER_STATS_EN
    // ---------------- per-frame token statistics ----------------
    logic [15:0] r_frame_cnt;
    logic [15:0] r_frame_tokens;
    logic [16:0] w_cnt_sum;
    logic [15:0] w_cnt_sat;

    // r_eof_pix is aligned with the push of the eof pixel's own tokens.
    assign w_cnt_sum = {1'b0, r_frame_cnt} + 17'(w_n_store);
    assign w_cnt_sat = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_frame_cnt    <= '0;
            r_frame_tokens <= '0;
        end else if (r_eof_pix) begin
            r_frame_tokens <= w_cnt_sat;
            r_frame_cnt    <= '0;
        end else begin
            r_frame_cnt    <= w_cnt_sat;
        end
    end

    assign bus.frame_tokens = r_frame_tokens;
`endif
endmodule

// File: tb/tb_rle_token_packer.sv
// ----------------------------------------------------------------------------
// tb_rle_token_packer
//   Drives two packers (LEN_W=11 and LEN_W=4) with the same pixel stream.
//   Expected tokens come from a line-level model (split each line into runs,
//   split each run into chunks of at most 2^LEN_W-1) and are queued when the
//   closing pixel is driven; per-DUT monitors pop and compare on each pop.
// ----------------------------------------------------------------------------
module tb_rle_token_packer;
    localparam int DEPTH = 16;

    logic CLK = 1'b0;
    logic reset_n;
    always #5 CLK = ~CLK;

    rle_token_packer_if #(.LEN_W(11)) bus11 ();
    rle_token_packer_if #(.LEN_W(4))  bus4  ();

    rle_token_packer #(.LEN_W(11), .DEPTH(DEPTH)) u_dut11 (
        .CLK(CLK), .reset_n(reset_n), .bus(bus11)
    );
    rle_token_packer #(.LEN_W(4), .DEPTH(DEPTH)) u_dut4 (
        .CLK(CLK), .reset_n(reset_n), .bus(bus4)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb11[$];
    logic [31:0] sb4[$];
    bit          hold_mode = 1'b0;
    int          kept11, kept4;
    bit          rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, got timeout expected completion", name);
    endtask

    function automatic logic [31:0] mk_tok(input bit v, input bit e, input bit f,
                                           input int len, input int lw);
        return (32'(v) << (lw + 2)) | (32'(e) << (lw + 1)) | (32'(f) << lw) | 32'(len);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input bit b, input bit v, input bit e, input bit f);
        bus11.bit_in = b; bus11.bit_valid = v; bus11.eol = e; bus11.eof = f;
        bus4.bit_in  = b; bus4.bit_valid  = v; bus4.eol  = e; bus4.eof  = f;
    endtask

    task automatic set_ready(input bit r);
        bus11.token_ready = r;
        bus4.token_ready  = r;
    endtask

    // Line model: tokens plus the index of the pixel that closes each one.
    task automatic build(input bit pix[$], input bit eol, input bit eof, input int lw,
                         output logic [31:0] tq[$], output int cq[$]);
        int maxl, n, s, e, off, c;
        bit last;
        maxl = (1 << lw) - 1;
        n = pix.size();
        tq = {};
        cq = {};
        s = 0;
        while (s < n) begin
            e = s;
            while (e < n && pix[e] == pix[s]) e++;
            off = s;
            while (off < e) begin
                c = (e - off < maxl) ? e - off : maxl;
                last = (off + c == n);
                if (!last || eol) begin
                    tq.push_back(mk_tok(pix[s], last, last && eof, c, lw));
                    cq.push_back(last ? n - 1 : off + c);
                end
                off += c;
            end
            s = e;
        end
    endtask

    task automatic wait_room();
        int guard;
        guard = 0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        while (sb11.size() > DEPTH - 3 || sb4.size() > DEPTH - 3) begin
            tick();
            guard++;
            if (guard > 2000) begin
                timeout("room");
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (sb11.size() != 0 || sb4.size() != 0) begin
            tick();
            guard++;
            if (guard > 2000) begin
                timeout(name);
                break;
            end
        end
        repeat (2) tick();
    endtask

    task automatic drive_line(input bit pix[$], input bit eol, input bit eof, input int idle_max);
        logic [31:0] t11[$], t4[$];
        int c11[$], c4[$];
        int nidle, last;
        build(pix, eol, eof, 11, t11, c11);
        build(pix, eol, eof, 4, t4, c4);
        last = pix.size() - 1;
        for (int i = 0; i <= last; i++) begin
            nidle = (idle_max > 0) ? int'($urandom_range(idle_max, 0)) : 0;
            repeat (nidle) begin
                set_in(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
                tick();
            end
            if (!hold_mode) wait_room();
            set_in(pix[i], 1'b1, eol && i == last, eof && i == last);
            while (c11.size() != 0 && c11[0] == i) begin
                void'(c11.pop_front());
                if (!hold_mode || kept11 < DEPTH) begin
                    sb11.push_back(t11.pop_front());
                    kept11++;
                end else void'(t11.pop_front());
            end
            while (c4.size() != 0 && c4[0] == i) begin
                void'(c4.pop_front());
                if (!hold_mode || kept4 < DEPTH) begin
                    sb4.push_back(t4.pop_front());
                    kept4++;
                end else void'(t4.pop_front());
            end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- monitors ----------------
    logic [31:0] prev11, prev4;
    bit          stall11 = 1'b0, stall4 = 1'b0;

    always @(negedge CLK) begin
        if (stall11 && bus11.token_valid) check("dut11 stable", 32'(bus11.token_data), prev11);
        if (bus11.token_valid && bus11.token_ready) begin
            if (sb11.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut11 token: got 0x%0h expected none", bus11.token_data);
            end else check("dut11 token", 32'(bus11.token_data), sb11.pop_front());
        end
        stall11 = bus11.token_valid && !bus11.token_ready;
        prev11  = 32'(bus11.token_data);
    end

    always @(negedge CLK) begin
        if (stall4 && bus4.token_valid) check("dut4 stable", 32'(bus4.token_data), prev4);
        if (bus4.token_valid && bus4.token_ready) begin
            if (sb4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4 token: got 0x%0h expected none", bus4.token_data);
            end else check("dut4 token", 32'(bus4.token_data), sb4.pop_front());
        end
        stall4 = bus4.token_valid && !bus4.token_ready;
        prev4  = 32'(bus4.token_data);
    end

    always @(posedge CLK) begin
        #1;
        if (rnd_ready) set_ready($urandom_range(3, 0) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit pix[$];
        int n, hi11, hi4;
        bit cur;

        reset_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        set_ready(1'b0);
        #12;
        check("reset valid", 32'(bus11.token_valid), 0);
        check("reset data", 32'(bus11.token_data), 0);
        check("reset overflow", 32'(bus11.overflow), 0);
        check("reset valid4", 32'(bus4.token_valid), 0);
`ifdef RLE_PACKER_STATS_EN
        check("reset frame_tokens", 32'(bus11.frame_tokens), 0);
`endif
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        set_ready(1'b1);

        // 640-pixel line of ones, plus latency of its single token
        pix = {};
        repeat (640) pix.push_back(1'b1);
        drive_line(pix, 1'b1, 1'b0, 0);
        @(negedge CLK);
        check("latency early", 32'(bus11.token_valid), 0);
        @(negedge CLK);
        check("latency", 32'(bus11.token_valid), 1);
        tick();
        wait_drain("line640");

        pix = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        drive_line(pix, 1'b1, 1'b0, 0);
        wait_drain("line2");

        pix = {1'b1, 1'b0, 1'b1, 1'b0};
        drive_line(pix, 1'b1, 1'b0, 0);
        pix = {1'b1};
        drive_line(pix, 1'b1, 1'b1, 0);
        wait_drain("line3");
`ifdef RLE_PACKER_STATS_EN
        check("frame_tokens dut11", 32'(bus11.frame_tokens), 9);
        check("frame_tokens dut4", 32'(bus4.frame_tokens), 51);
`endif

        pix = {};
        repeat (20) pix.push_back(1'b1);
        drive_line(pix, 1'b1, 1'b0, 0);
        wait_drain("line20");

        // randomized lines with random back-pressure and idle cycles
        rnd_ready = 1'b1;
        for (int l = 0; l < 60; l++) begin
            n = int'($urandom_range(50, 1));
            cur = 1'($urandom);
            pix = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3, 0) == 0) cur = ~cur;
                pix.push_back(cur);
            end
            if (l % 8 == 0) repeat (35) pix.push_back(cur);
            drive_line(pix, 1'b1, $urandom_range(4, 0) == 0, 2);
        end
        rnd_ready = 1'b0;
        tick();
        set_ready(1'b1);
        wait_drain("random");
        check("no overflow dut11", 32'(bus11.overflow), 0);
        check("no overflow dut4", 32'(bus4.overflow), 0);

        // overflow: 20 tokens into a 16-deep FIFO with no consumer
        set_ready(1'b0);
        hold_mode = 1'b1;
        kept11 = 0;
        kept4 = 0;
        pix = {};
        for (int i = 0; i < 20; i++) pix.push_back(1'(i % 2));
        drive_line(pix, 1'b1, 1'b0, 0);
        repeat (3) tick();
        hold_mode = 1'b0;
        check("overflow dut11", 32'(bus11.overflow), 1);
        check("overflow dut4", 32'(bus4.overflow), 1);
        set_ready(1'b1);
        hi11 = 0;
        hi4 = 0;
        repeat (DEPTH) begin
            @(negedge CLK);
            if (bus11.token_valid) hi11++;
            if (bus4.token_valid) hi4++;
        end
        @(negedge CLK);
        check("drain b2b dut11", 32'(hi11), DEPTH);
        check("drain b2b dut4", 32'(hi4), DEPTH);
        check("drain empty", 32'(bus11.token_valid), 0);
        tick();
        check("drained sb", 32'(sb11.size() + sb4.size()), 0);

        // reset in the middle of an open run with tokens buffered
        set_ready(1'b0);
        pix = {1'b1, 1'b0, 1'b1};
        repeat (97) pix.push_back(1'b0);
        drive_line(pix, 1'b0, 1'b0, 0);
        check("buffered before reset", 32'(bus11.token_valid), 1);
        reset_n = 1'b0;
        #1;
        check("reset mid valid", 32'(bus11.token_valid), 0);
        check("reset mid overflow", 32'(bus11.overflow), 0);
        check("reset mid valid4", 32'(bus4.token_valid), 0);
        sb11.delete();
        sb4.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        set_ready(1'b1);
        pix = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        drive_line(pix, 1'b1, 1'b0, 0);
        wait_drain("after reset");
`ifdef RLE_PACKER_STATS_EN
        check("frame_tokens after reset", 32'(bus11.frame_tokens), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rle_token_packer.md
# rle_token_packer

- Run-length encodes the binarised pixel mask into tokens of the form {value, end-of-line, end-of-frame, length}.
- Buffers the tokens in a small FIFO and presents them on a valid/ready output.
- Sits directly downstream of the pixel binarising stage and upstream of the RLE decoder/transport.
- Replaces the stateless streak encoder, which cannot cope with short alternating streaks: every run, however short, produces exactly one token and none are merged or lost unless the FIFO overflows.

## Interface

Parameters:
- LEN_W, 11: width of the run-length field; the maximum run length is 2^LEN_W-1.
- DEPTH, 16: token FIFO depth; a power of two, at least 4.

Ports:
- CLK  input  1  pixel clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bit_in  input  1  mask value of the current pixel.
- bit_valid  input  1  bit_in is a valid pixel this cycle; the input cannot be stalled.
- eol  input  1  the current valid pixel is the last one of its line.
- eof  input  1  the current valid pixel is the last one of the frame; eof implies eol.
- token_valid  output  1  token_data holds a token.
- token_ready  input  1  the consumer accepts the token this cycle.
- token_data  output  LEN_W+3  token, laid out as [LEN_W+2]=value, [LEN_W+1]=eol, [LEN_W]=eof, [LEN_W-1:0]=length.
- overflow  output  1  sticky; set when any token has been dropped.

## Operation

Run state machine:
- IDLE: no open run.
  - A valid pixel opens a run with value bit_in and length 1, then goes to RUN.
  - If that pixel also has eol, the 1-pixel run is emitted with eol set and the state stays IDLE.
- RUN, valid pixel with the same value and length < MAX: length increments.
- RUN, same value and length == MAX: emit {value, 0, 0, MAX}, then open a new run of length 1 with the same value.
- RUN, different value: emit the open run with eol=0, then open a new run of bit_in with length 1.
- RUN, pixel with eol: the pixel first joins or opens a run as above, then that run is emitted with eol=1 and eof=eof, and the state returns to IDLE.
- Emission count per pixel:
  - A value change or saturation together with eol emits two tokens in the same cycle, oldest first.
  - No pixel ever emits more than two tokens.
- Cycles with bit_valid=0 change nothing. eol and eof are ignored when bit_valid=0.
- A run never spans a line boundary, so no token has length 0.

FIFO:
- First-word-fall-through, with up to two pushes per cycle.
- Pushes and a pop may happen in the same cycle.
- Pop occurs when token_valid && token_ready.
- Free space is evaluated before that cycle's pop.
- When two tokens are pushed but only one slot is free, the older token is stored, the newer is dropped, and overflow is set.
- With zero free slots, all of that cycle's pushes are dropped and overflow is set.
- overflow clears only on reset.
- Dropping tokens does not disturb the run state machine.

## Timing

- Latency: a token closed by the pixel sampled at edge N is on token_data with token_valid=1 after edge N+1, provided the FIFO was empty.
- When two tokens are pushed together, the second token follows the first on the first cycle after the first is popped.
- token_data is stable while token_valid=1 && token_ready=0.
- Sustained throughput is one pop per cycle.
- Reset values (asynchronous, immediate):
  - token_valid=0, token_data=0, overflow=0.
  - FIFO empty, state IDLE, run length 0.
- Reset mid-run discards the open run and all buffered tokens.
- The first valid pixel after reset_n rises opens a fresh run.
- reset_n deassertion is synchronised internally with a 2-flop release.

## Configuration

- RLE_PACKER_STATS_EN defined:
  - Adds output frame_tokens (16 bits, reset 0).
  - An internal counter counts tokens successfully pushed (not dropped) since the last eof pixel, including the tokens pushed on that eof pixel itself.
  - The count is copied to frame_tokens on the eof pixel, and the internal counter restarts from 0.
  - The counter saturates at 0xFFFF.
- RLE_PACKER_STATS_EN undefined: no port and no counter logic.

## Test plan

1. One line of 640 pixels, all 1, eol on the last pixel, token_ready=1 -> exactly one token {1,1,0,640}, appearing 1 cycle after the eol pixel.
2. Line 0,0,0,1,1,1,1,1,0,0 with eol on the last pixel -> tokens {0,0,0,3}, {1,0,0,5}, {0,1,0,2}, in that order.
3. Pixels 1,0,1,0 with eol on the last pixel, and eof on a second line consisting of a single pixel 1:
   - First line -> four length-1 tokens, the last with eol=1; the final pixel exercises dual push.
   - Second line -> {1,1,1,1}.
4. LEN_W=4, a line of 20 ones with eol on the last pixel -> {1,0,0,15} then {1,1,0,5}.
5. DEPTH=16, token_ready=0, 20 alternating pixels (20 tokens) -> the first 16 tokens are retained and overflow=1. Raising token_ready then drains tokens 1 to 16 in order, back-to-back, and token_valid falls.
6. Assert reset_n low at pixel 100 of an open run with 3 tokens buffered -> token_valid and overflow go 0 immediately. After release, a 5-pixel line of zeros yields only {0,1,0,5}. With RLE_PACKER_STATS_EN defined, frame_tokens=0 until the next eof.
